// File: rtl/atom_mem_arbiter.sv
// Shares the single-port Atom memory array between the core bus and the HPS ioctl download stream.
// Optional download checksum output dl_sum is built when ATOM_DL_CHECKSUM_EN is defined.
module atom_mem_arbiter #(
    parameter int                ADDR_W     = 18,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] DL_BASE    = ADDR_W'(18'h17000),
    parameter int                DL_SIZE    = 4096
) (
    input  logic              clk_main,
    input  logic              reset_n,
    input  logic              cpu_ce,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [24:0]       dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_wait,
    output logic              dl_err,
    output logic              cpu_hold,
`ifdef ATOM_DL_CHECKSUM_EN
    output logic [7:0]        dl_sum,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    input  logic [7:0]        mem_dout
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        FLUSH   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [7:0]        fifo_data [FIFO_DEPTH];
    logic [11:0]       fifo_off  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              dl_active_q;
    logic              dl_rise;
    logic              fifo_empty, fifo_full, in_window;
    logic              wr_req, push, drop, pop, grant_cpu;
    logic              rd_pending_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [7:0]        last_din_q;

    assign dl_rise    = dl_active && !dl_active_q;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign in_window  = (dl_addr < 25'(DL_SIZE));

    assign wr_req = (state_q == LOAD) && dl_wr;
    assign push   = wr_req && !fifo_full && in_window;
    assign drop   = wr_req && (fifo_full || !in_window);

    // Grants are gated by reset so an asserted reset can never leak a write to the array.
    assign grant_cpu = reset_n && cpu_ce;
    assign pop       = reset_n && !cpu_ce && !fifo_empty;

    assign cpu_hold  = (state_q != IDLE);

    // Combinational port mux; an idle port replays the last address and data.
    always_comb begin
        mem_addr = last_addr_q;
        mem_din  = last_din_q;
        mem_we   = 1'b0;
        if (grant_cpu) begin
            mem_addr = cpu_addr;
            mem_din  = cpu_din;
            mem_we   = cpu_we;
        end else if (pop) begin
            mem_addr = DL_BASE + ADDR_W'(fifo_off[rd_ptr_q]);
            mem_din  = fifo_data[rd_ptr_q];
            mem_we   = 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dl_active)  state_d = LOAD;
            LOAD:    if (!dl_active) state_d = FLUSH;
            FLUSH:   if (fifo_empty) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_main or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dl_active_q  <= 1'b0;
            dl_wait      <= 1'b0;
            dl_err       <= 1'b0;
            rd_pending_q <= 1'b0;
            cpu_dout     <= 8'h00;
            last_addr_q  <= '0;
            last_din_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            dl_active_q  <= dl_active;
            count_q      <= count_d;
            dl_wait      <= (count_d >= CNT_W'(FIFO_DEPTH - 1));
            last_addr_q  <= mem_addr;
            last_din_q   <= mem_din;
            rd_pending_q <= grant_cpu && !cpu_we;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (rd_pending_q) cpu_dout <= mem_dout;
            if (dl_rise)   dl_err <= 1'b0;
            else if (drop) dl_err <= 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk_main) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= dl_data;
            fifo_off[wr_ptr_q]  <= dl_addr[11:0];
        end
    end

`ifdef ATOM_DL_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk_main or negedge reset_n) begin
        if (!reset_n)     sum_q <= 8'h00;
        else if (dl_rise) sum_q <= 8'h00;
        else if (pop)     sum_q <= sum_q + mem_din;
    end

    assign dl_sum = sum_q;
`endif

endmodule

// File: tb/tb_atom_mem_arbiter.sv
// Directed bench for atom_mem_arbiter with a behavioural single-port array model.
// Checksum steps run only when ATOM_DL_CHECKSUM_EN is defined.
module tb_atom_mem_arbiter;

    logic        clk_main = 1'b0;
    logic        reset_n;
    logic        cpu_ce, cpu_we;
    logic [17:0] cpu_addr;
    logic [7:0]  cpu_din, cpu_dout;
    logic        dl_active, dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wait, dl_err, cpu_hold;
    logic [17:0] mem_addr;
    logic [7:0]  mem_din, mem_dout;
    logic        mem_we;
`ifdef ATOM_DL_CHECKSUM_EN
    logic [7:0]  dl_sum;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [262144];

    always #5 clk_main = ~clk_main;

    atom_mem_arbiter dut (
        .clk_main (clk_main),
        .reset_n  (reset_n),
        .cpu_ce   (cpu_ce),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .dl_active(dl_active),
        .dl_wr    (dl_wr),
        .dl_addr  (dl_addr),
        .dl_data  (dl_data),
        .dl_wait  (dl_wait),
        .dl_err   (dl_err),
        .cpu_hold (cpu_hold),
`ifdef ATOM_DL_CHECKSUM_EN
        .dl_sum   (dl_sum),
`endif
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_dout (mem_dout)
    );

    // spram model: write at the edge, read data registered one cycle after the address edge.
    always @(posedge clk_main) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_main);
        #2;
    endtask

    task automatic set_dl(input logic wr, input logic [24:0] addr, input logic [7:0] data);
        dl_wr   = wr;
        dl_addr = addr;
        dl_data = data;
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 8'h00;
        mem[18'h0C000] = 8'h4C;

        reset_n = 1'b0;
        cpu_ce = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        dl_active = 1'b0;
        set_dl(1'b0, '0, '0);
        #1;
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_dl_wait", dl_wait, 0);
        check("rst_dl_err", dl_err, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_din", mem_din, 0);
        check("rst_cpu_dout", cpu_dout, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Core write and read while idle
        cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h00100; cpu_din = 8'h3C;
        #1;
        check("cpu_wr_mem_we", mem_we, 1);
        check("cpu_wr_mem_din", mem_din, 8'h3C);
        tick();
        check("cpu_wr_commit", mem[18'h00100], 8'h3C);
        cpu_we = 1'b0;
        tick();
        cpu_ce = 1'b0;
        tick();
        check("cpu_rd_dout", cpu_dout, 8'h3C);

        // Download A0..A3 with no core traffic
        dl_active = 1'b1;
        #1;
        check("hold_before_edge", cpu_hold, 0);
        tick();
        check("hold_rise", cpu_hold, 1);
        for (int i = 0; i < 4; i++) begin
            set_dl(1'b1, 25'(i), 8'hA0 + 8'(i));
            tick();
            #1;
            check("dl_drain_we", mem_we, 1);
            check("dl_drain_addr", mem_addr, 18'h17000 + 18'(i));
            check("dl_drain_din", mem_din, 8'hA0 + 8'(i));
        end
        set_dl(1'b0, '0, '0);
        dl_active = 1'b0;
        tick();
        check("last_write_a3", mem[18'h17003], 8'hA3);
        check("idle_mem_we", mem_we, 0);
        check("idle_addr_hold", mem_addr, 18'h17003);
        check("hold_after_last_plus0", cpu_hold, 1);
        tick();
        check("hold_after_last_plus1", cpu_hold, 1);
        tick();
        check("hold_after_last_plus2", cpu_hold, 0);
        for (int i = 0; i < 4; i++) check("dl_array", mem[18'h17000 + 18'(i)], 8'hA0 + 8'(i));
        check("dl_err_clean", dl_err, 0);

        // Core read collides with a pending drain
        dl_active = 1'b1;
        tick();
        set_dl(1'b1, 25'h00A, 8'h5A);
        tick();
        set_dl(1'b0, '0, '0);
        cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h0C000;
        #1;
        check("collide_core_wins_we", mem_we, 0);
        check("collide_core_addr", mem_addr, 18'h0C000);
        tick();
        cpu_ce = 1'b0;
        #1;
        check("retry_we", mem_we, 1);
        check("retry_addr", mem_addr, 18'h1700A);
        tick();
        check("collide_cpu_dout", cpu_dout, 8'h4C);
        check("retry_written", mem[18'h1700A], 8'h5A);
        dl_active = 1'b0;
        tick(); tick(); tick();
        check("collide_hold_end", cpu_hold, 0);

        // Six consecutive bytes with the core holding the port
        dl_active = 1'b1;
        tick();
        cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h0C000;
        for (int i = 0; i < 6; i++) begin
            set_dl(1'b1, 25'h020 + 25'(i), 8'h10 + 8'(i));
            tick();
            check("ovf_dl_wait", dl_wait, (i >= 2) ? 1 : 0);
            check("ovf_dl_err", dl_err, (i >= 4) ? 1 : 0);
        end
        set_dl(1'b0, '0, '0);
        cpu_ce = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("ovf_drain_addr", mem_addr, 18'h17020 + 18'(i));
            tick();
        end
        for (int i = 0; i < 4; i++) check("ovf_array", mem[18'h17020 + 18'(i)], 8'h10 + 8'(i));
        check("ovf_drop5", mem[18'h17024], 8'h00);
        check("ovf_drop6", mem[18'h17025], 8'h00);
        dl_active = 1'b0;
        tick(); tick(); tick();
        check("ovf_err_sticky", dl_err, 1);

        // Window boundary: 4095 accepted, 4096 dropped
        dl_active = 1'b1;
        tick();
        check("rise_clears_err", dl_err, 0);
        set_dl(1'b1, 25'd4096, 8'h77);
        tick();
        check("oow_err", dl_err, 1);
        check("oow_no_write", mem_we, 0);
        set_dl(1'b1, 25'd4095, 8'h66);
        tick();
        set_dl(1'b0, '0, '0);
        #1;
        check("edge_addr", mem_addr, 18'h17FFF);
        dl_active = 1'b0;
        tick(); tick(); tick();
        check("edge_written", mem[18'h17FFF], 8'h66);
        check("oow_no_wrap", mem[18'h17000], 8'hA0);
        check("oow_err_held", dl_err, 1);
        dl_active = 1'b1;
        tick();
        check("next_rise_clears", dl_err, 0);

        // Reset with two bytes queued behind the core
        cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h0C000;
        set_dl(1'b1, 25'h030, 8'hC0);
        tick();
        set_dl(1'b1, 25'h031, 8'hC1);
        tick();
        set_dl(1'b0, '0, '0);
        reset_n = 1'b0;
        #1;
        check("rst_mid_hold", cpu_hold, 0);
        check("rst_mid_we", mem_we, 0);
        check("rst_mid_wait", dl_wait, 0);
        cpu_ce = 1'b0;
        dl_active = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        check("rst_fifo_empty_we", mem_we, 0);
        tick();
        check("rst_drop_b0", mem[18'h17030], 8'h00);
        check("rst_drop_b1", mem[18'h17031], 8'h00);

`ifdef ATOM_DL_CHECKSUM_EN
        dl_active = 1'b1;
        tick();
        set_dl(1'b1, 25'h040, 8'hFF);
        tick();
        set_dl(1'b1, 25'h041, 8'h02);
        tick();
        set_dl(1'b0, '0, '0);
        dl_active = 1'b0;
        tick();
        tick();
        check("sum_release", dl_sum, 8'h01);
        tick();
        check("sum_stable", dl_sum, 8'h01);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/atom_mem_arbiter.md
# atom_mem_arbiter

Shares the single-port 192 KiB Atom memory array (18-bit address, 8-bit data) between the AtomFpga core's external bus and the HPS ioctl download stream, so a utility ROM image can be loaded into the RAM slot at 0x17000 while the core is held off. Download bytes pass through a small write FIFO. The FIFO drains into the array only on cycles the core does not claim. The block sits between the core's `ExternA/ExternDin/ExternDout/ExternWE` pins and the `spram` instance.

## Interface
- `ADDR_W`, 18, memory array address width
- `FIFO_DEPTH`, 4, download write FIFO entries (power of two, ≥2)
- `DL_BASE`, 18'h17000, array address of download byte 0
- `DL_SIZE`, 4096, download window size in bytes

Ports:
- `clk_main` in 1: system clock; all logic on the rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `cpu_ce` in 1: core memory access strobe, one cycle per access
- `cpu_we` in 1: core write, qualified by `cpu_ce`
- `cpu_addr` in ADDR_W: core address
- `cpu_din` in 8: core write data
- `cpu_dout` out 8: registered read data to core
- `dl_active` in 1: ioctl download for this block's index in progress
- `dl_wr` in 1: one-cycle download byte strobe
- `dl_addr` in 25: download byte offset
- `dl_data` in 8: download byte
- `dl_wait` out 1: back-pressure to hps_io (`ioctl_wait`)
- `dl_err` out 1: sticky; a byte was dropped (overflow or out of window)
- `cpu_hold` out 1: hold the core in reset
- `mem_addr` out ADDR_W, `mem_din` out 8, `mem_we` out 1: to spram
- `mem_dout` in 8: spram read data, valid one cycle after the address edge

## Operation
- FSM states:
  - IDLE → LOAD on `dl_active`=1.
  - LOAD → FLUSH on `dl_active`=0.
  - FLUSH → RELEASE when the FIFO is empty.
  - RELEASE → IDLE after one cycle.
- `cpu_hold` = (state ≠ IDLE). A `dl_active` rising edge in any state clears `dl_err`.
- Port grant is combinational:
  - `cpu_ce`=1: the core owns the array. `mem_addr`=`cpu_addr`, `mem_din`=`cpu_din`, `mem_we`=`cpu_we`.
  - Otherwise, if the FIFO is non-empty: pop head, `mem_addr`=`DL_BASE`+offset[11:0], `mem_we`=1.
  - Otherwise: `mem_we`=0 and `mem_addr` holds its last value.
- Core always wins. A drain pending in the same cycle as `cpu_ce` is retried on the next free cycle.
- Push accepts `dl_wr` only in LOAD. A byte is pushed only if the FIFO is not full and `dl_addr` < `DL_SIZE`.
  - Full FIFO: drop the byte and set `dl_err`.
  - `dl_addr` ≥ `DL_SIZE`: drop the byte and set `dl_err`.
  - `dl_wr` while not in LOAD: ignored.
- Push and pop in the same cycle: occupancy unchanged.
- Pointer and address arithmetic is modulo width, no carries. Offset is stored as 12 bits.
- `dl_wait` = (occupancy ≥ `FIFO_DEPTH`−1), registered.
- `cpu_dout` is loaded from `mem_dout` the cycle after a granted core read, and holds otherwise.

## Timing
- Reset values:
  - state IDLE, FIFO empty.
  - `cpu_dout`=8'h00, `dl_wait`=0, `dl_err`=0, `cpu_hold`=0.
  - `mem_we`=0, `mem_addr`=0, `mem_din`=0.
- Core read: `cpu_ce` at edge N → `cpu_dout` valid after edge N+1.
- Core write: committed at the edge where `cpu_ce`=1.
- Download byte: the earliest array write is the cycle after the push edge, with zero-wait latency of 1 cycle.
- `cpu_hold` rises the cycle after `dl_active` rises. It falls two cycles after the last drain write (FLUSH→RELEASE→IDLE).
- Reset mid-download: FIFO contents are discarded and the block returns to IDLE asynchronously. No partial write is issued after reset asserts.

## Configuration
- `ATOM_DL_CHECKSUM_EN` defined:
  - adds output `dl_sum` out 8: the modulo-256 sum of every byte actually written to the array by the drain path;
  - cleared on the `dl_active` rising edge;
  - stable from RELEASE onward.
- Undefined: `dl_sum` is absent and no accumulator is built.

## Test plan
- Reset, then download offsets 0..3 with data 8'hA0..A3, no core traffic → `cpu_hold`=1 during the transfer. Array 0x17000..0x17003 = A0..A3. `cpu_hold` falls 2 cycles after the last write. `dl_err`=0.
- Core reads 0x0C000 (ROM byte 8'h4C) on the same cycle a FIFO entry is pending → `cpu_dout`=8'h4C one cycle later. The FIFO entry is written on the following free cycle.
- Assert `dl_wr` on 6 consecutive cycles with `cpu_ce` held high → `dl_wait` rises at occupancy 3. The 5th and 6th bytes are dropped and `dl_err`=1. The first 4 bytes land after `cpu_ce` drops.
- Download at `dl_addr`=4096 → no array write, `dl_err`=1. The next `dl_active` rising edge clears `dl_err`.
- Deassert `reset_n` with 2 bytes queued → `cpu_hold`=0, FIFO empty and `mem_we`=0 immediately. Neither byte appears in the array.
- With `ATOM_DL_CHECKSUM_EN`: download bytes 8'hFF, 8'h02 → `dl_sum`=8'h01 in RELEASE.
